// File: rtl/zx48_pkg.sv
// ---------------------------------------------------------------------------
// zx48_pkg -- shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e : frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_EXT     : extended-key prefix byte (E0)
//   PS2_REL     : key-release prefix byte (F0)
//   odd_weight  : 1 when the vector has an odd number of ones
// ---------------------------------------------------------------------------
package zx48_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  function automatic logic odd_weight(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// ---------------------------------------------------------------------------
// ps2_filter -- 2-FF synchroniser followed by a level filter for one PS/2
// pad line. The filtered level only follows the synchronised input after
// FILTER_LEN consecutive ce samples of the new level, which suppresses
// glitches and slow edges on the keyboard cable.
// Ports:
//   clock   : system clock (rising edge)
//   reset   : synchronous active-high reset; all stages return to 1
//   ce      : sampling enable for the filter counter
//   pad_i   : raw asynchronous pad level
//   level_o : filtered level
// ---------------------------------------------------------------------------
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic pad_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      if (ce) begin
        // cnt_q holds how many consecutive samples disagreed so far; the
        // FILTER_LEN-th disagreeing sample commits the new level.
        if (sync_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
          level_q <= sync_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx -- PS/2 keyboard receiver. Filters the pad lines, deserialises
// 11-bit frames on filtered clock falls and folds E0/F0 prefixes into the
// extended/pressed flags of the next scancode.
// Optional macro: PS2_PARITY_CHECK_EN -- when defined a parity mismatch
// rejects the frame; otherwise parity is sampled but ignored.
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   ce               : filter sampling enable
//   ps2Ck, ps2Dt     : raw asynchronous PS/2 clock and data
//   code             : last scancode (prefixes excluded)
//   strobe           : one-cycle pulse when code/pressed/extended update
//   pressed          : 1 = make, 0 = break
//   extended         : 1 = code was preceded by E0
//   error            : one-cycle pulse on rejected frame or timeout
//   state_o          : current frame FSM state (debug)
// Output handshake: strobe is a valid-only qualifier with no ready; the
// consumer must capture code/pressed/extended on the strobe cycle, although
// they also hold until the next strobe.
// ---------------------------------------------------------------------------
module ps2_rx
  import zx48_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2Dt,
  output logic [7:0] code,
  output logic       strobe,
  output logic       pressed,
  output logic       extended,
  output logic       error,
  output ps2_state_e state_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic ck_f;
  logic dt_f;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_ck_filter (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .pad_i  (ps2Ck),
    .level_o(ck_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dt_filter (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .pad_i  (ps2Dt),
    .level_o(dt_f)
  );

  ps2_state_e    state_q;
  logic          ck_prev_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          ext_flag_q;
  logic          rel_flag_q;
  logic [7:0]    code_q;
  logic          pressed_q;
  logic          extended_q;
  logic          strobe_q;
  logic          error_q;

  logic fall;
  logic frame_ok;

  // Single-cycle event: filtered clock was high last cycle and is low now.
  assign fall = ck_prev_q & ~ck_f;

  // Evaluated during the stop-bit fall: dt_f is the stop bit itself.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dt_f & odd_weight({shift_q, parity_q});
`else
  logic unused_parity;
  assign unused_parity = parity_q;
  assign frame_ok      = dt_f;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ck_prev_q  <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_flag_q <= 1'b0;
      rel_flag_q <= 1'b0;
      code_q     <= 8'h00;
      pressed_q  <= 1'b0;
      extended_q <= 1'b0;
      strobe_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ck_prev_q <= ck_f;
      strobe_q  <= 1'b0;
      error_q   <= 1'b0;

      if (fall) begin
        tmo_q <= '0;
        unique case (state_q)
          IDLE: begin
            // A fall with data high is not a start bit; ignore it quietly.
            if (!dt_f) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
          DATA: begin
            shift_q   <= {dt_f, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= dt_f;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (frame_ok) begin
              if (shift_q == PS2_EXT) begin
                ext_flag_q <= 1'b1;
              end else if (shift_q == PS2_REL) begin
                rel_flag_q <= 1'b1;
              end else begin
                code_q     <= shift_q;
                pressed_q  <= ~rel_flag_q;
                extended_q <= ext_flag_q;
                strobe_q   <= 1'b1;
                ext_flag_q <= 1'b0;
                rel_flag_q <= 1'b0;
              end
            end else begin
              error_q    <= 1'b1;
              ext_flag_q <= 1'b0;
              rel_flag_q <= 1'b0;
            end
          end
        endcase
      end else if (state_q != IDLE) begin
        // Abort a stalled frame; prefix flags survive so a slow keyboard
        // may still send the byte that follows an E0/F0.
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_q   <= IDLE;
          tmo_q     <= '0;
          bit_cnt_q <= '0;
          shift_q   <= '0;
          error_q   <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign code     = code_q;
  assign strobe   = strobe_q;
  assign pressed  = pressed_q;
  assign extended = extended_q;
  assign error    = error_q;
  assign state_o  = state_q;

endmodule
